// File: rtl/op_sequencer_if.sv
// rtl/op_sequencer_if.sv - host command/data streams and controller-side buses of op_sequencer
interface op_sequencer_if;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        dat_valid;
    logic [31:0] dat_data;
    logic        dat_ready;
    logic [31:0] operation;
    logic [31:0] in_data;
    logic [31:0] out_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output cmd_valid, cmd_data, dat_valid, dat_data, out_data,
        input  cmd_ready, dat_ready, operation, in_data, rd_data, rd_valid
    );

    modport slave (
        input  cmd_valid, cmd_data, dat_valid, dat_data, out_data,
        output cmd_ready, dat_ready, operation, in_data, rd_data, rd_valid
    );
endinterface

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - command/data buffering sequencer that times controller operations
module op_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  count_next;
    logic         full;
    logic         push_ok;
    logic         pop_ok;

    assign count      = wptr - rptr;
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && (count != '0);
    assign rdata      = mem[rptr[AW-1:0]];
    assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    // Pointers wrap through the extra MSB; ready is the registered "not full" of the updated occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            ready <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + (AW+1)'(1);
            if (pop_ok)  rptr <= rptr + (AW+1)'(1);
            ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module op_sequencer #(
    parameter int CMD_DEPTH  = 4,
    parameter int DAT_DEPTH  = 64,
    parameter int PAGE_WORDS = 64,
    parameter int MM_CYCLES  = 80,
    parameter int GAP_CYCLES = 2,
    parameter int READ_LAT   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    op_sequencer_if.slave bus,
    output logic          busy,
    output logic          err
);
    localparam int LEN_MAX = (MM_CYCLES > PAGE_WORDS) ? MM_CYCLES : PAGE_WORDS;
    localparam int CNT_W   = $clog2(LEN_MAX) + 1;
    localparam int CAW     = $clog2(CMD_DEPTH);
    localparam int DAW     = $clog2(DAT_DEPTH);

    localparam logic [CNT_W-1:0] MM_LAST  = CNT_W'(MM_CYCLES - 1);
    localparam logic [CNT_W-1:0] PG_LAST  = CNT_W'(PAGE_WORDS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      op_q;
    logic [31:0]      op_d;
    logic [31:0]      in_q;
    logic [31:0]      in_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0] gcnt_d;
    logic             err_q;
    logic             err_d;
    logic [31:0]      rd_data_q;
    logic             rd_valid_q;

    logic [31:0]      cmd_head;
    logic [CAW:0]     cmd_count;
    logic             cmd_rdy;
    logic             cmd_push;
    logic             cmd_pop;
    logic [31:0]      dat_head;
    logic [DAW:0]     dat_count;
    logic             dat_rdy;
    logic             dat_push;
    logic             dat_pop;

    logic [3:0]       head_op;
    logic             cmd_nempty;
    logic             dat_page;
    logic             issue_ok;
    logic             rd_flag;
    logic             rd_tap;

    assign bus.cmd_ready = cmd_rdy && enable;
    assign bus.dat_ready = dat_rdy && enable;
    assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
    assign dat_push      = bus.dat_valid && bus.dat_ready;

    op_seq_fifo #(.DEPTH(CMD_DEPTH), .W(32)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .wdata (bus.cmd_data),
        .rdata (cmd_head),
        .count (cmd_count),
        .ready (cmd_rdy)
    );

    op_seq_fifo #(.DEPTH(DAT_DEPTH), .W(32)) u_dat_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dat_push),
        .pop   (dat_pop),
        .wdata (bus.dat_data),
        .rdata (dat_head),
        .count (dat_count),
        .ready (dat_rdy)
    );

    assign head_op    = cmd_head[3:0];
    assign cmd_nempty = (cmd_count != '0);
    assign dat_page   = (dat_count >= (DAW+1)'(PAGE_WORDS));
    // A page write only launches once its whole page is buffered, so the data stream never underruns.
    assign issue_ok   = cmd_nempty && ((head_op == 4'd1) || (head_op == 4'd3) ||
                                       ((head_op == 4'd2) && dat_page));

    // State register; an abort by reset returns straight to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: IDLE issues legal commands, RUN lasts LEN cycles, GAP forces opcode-0 spacing.
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                S_IDLE:  if (issue_ok) state_d = S_RUN;
                S_RUN:   if (cnt_q == '0) state_d = S_GAP;
                S_GAP:   if (gcnt_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output/datapath decode: pops, next operation word, serial write data and counters.
    always_comb begin
        op_d    = op_q;
        in_d    = in_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        cmd_pop = 1'b0;
        dat_pop = 1'b0;
        err_d   = 1'b0;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_nempty) begin
                        case (head_op)
                            4'd0: cmd_pop = 1'b1;
                            4'd1, 4'd3: begin
                                cmd_pop = 1'b1;
                                op_d    = cmd_head;
                                cnt_d   = (head_op == 4'd1) ? MM_LAST : PG_LAST;
                            end
                            4'd2: begin
                                if (dat_page) begin
                                    cmd_pop = 1'b1;
                                    dat_pop = 1'b1;
                                    op_d    = cmd_head;
                                    in_d    = dat_head;
                                    cnt_d   = PG_LAST;
                                end
                            end
                            default: begin
                                cmd_pop = 1'b1;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        op_d   = '0;
                        in_d   = '0;
                        gcnt_d = GAP_LAST;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        // in_data is loaded alongside operation, so word k+1 is fetched on RUN cycle k.
                        if (op_q[3:0] == 4'd2) begin
                            dat_pop = 1'b1;
                            in_d    = dat_head;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt_q != '0) gcnt_d = gcnt_q - CNT_W'(1);
                end
                default: begin
                    op_d = '0;
                    in_d = '0;
                end
            endcase
        end
    end

    // Controller-facing registers and counters; reset clears operation asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            in_q   <= '0;
            cnt_q  <= '0;
            gcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            in_q   <= in_d;
            cnt_q  <= cnt_d;
            gcnt_q <= gcnt_d;
            err_q  <= err_d;
        end
    end

    assign rd_flag = (state_q == S_RUN) && (op_q[3:0] == 4'd3);

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rd_tap = rd_flag;
        end else begin : g_latn
            logic [READ_LAT-2:0] rd_sh;

            // Delay line aligning the read flag with the controller's out_data latency.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)      rd_sh <= '0;
                else if (enable) rd_sh <= (rd_sh << 1) | (READ_LAT-1)'(rd_flag);
            end

            assign rd_tap = rd_sh[READ_LAT-2];
        end
    endgenerate

    // Read capture: one beat per delayed flag, no backpressure; rd_valid drops while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (!enable) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_tap;
            if (rd_tap) rd_data_q <= bus.out_data;
        end
    end

    assign bus.operation = op_q;
    assign bus.in_data   = in_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign err           = err_q;
    assign busy          = (state_q != S_IDLE) || cmd_nempty || (dat_count != '0);
endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - scoreboard bench for op_sequencer
module tb_op_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy;
    logic err;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        int          cyc;
        logic [31:0] op;
        logic [31:0] din;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } rbeat_t;

    beat_t  op_q[$];
    rbeat_t rd_q[$];
    int     err_q[$];

    op_sequencer_if bus();

    op_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.out_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_data = cyc;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [95:0] act);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d: got %0h, required no beat", name, cyc, act);
    endtask

    // Scoreboard monitor: every presented output beat is matched against the queued expectation.
    beat_t  mb;
    rbeat_t mr;
    int     me;
    always @(negedge clk) begin
        if (bus.operation != 32'h0) begin
            if (op_q.size() == 0) miss("op_beat", {32'(cyc), bus.operation, bus.in_data});
            else begin
                mb = op_q.pop_front();
                chk("op_beat", {32'(cyc), bus.operation, bus.in_data}, {32'(mb.cyc), mb.op, mb.din});
            end
        end else if (bus.in_data != 32'h0) begin
            chk("in_data_idle", {64'h0, bus.in_data}, 96'h0);
        end
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) miss("rd_beat", {32'h0, 32'(cyc), bus.rd_data});
            else begin
                mr = rd_q.pop_front();
                chk("rd_beat", {32'h0, 32'(cyc), bus.rd_data}, {32'h0, 32'(mr.cyc), mr.d});
            end
        end
        if (err) begin
            if (err_q.size() == 0) miss("err_pulse", 96'(cyc));
            else begin
                me = err_q.pop_front();
                chk("err_pulse", 96'(cyc), 96'(me));
            end
        end
    end

    task automatic wait_to(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] d, output int c);
        int guard = 0;
        while (!bus.cmd_ready && guard < 100) begin align(); guard++; end
        if (!bus.cmd_ready) miss("push_cmd_timeout", 96'(d));
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        c = cyc;
        align();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_dat(input logic [31:0] d, output int c);
        int guard = 0;
        while (!bus.dat_ready && guard < 100) begin align(); guard++; end
        if (!bus.dat_ready) miss("push_dat_timeout", 96'(d));
        bus.dat_valid = 1'b1;
        bus.dat_data  = d;
        c = cyc;
        align();
        bus.dat_valid = 1'b0;
    endtask

    task automatic exp_run(input int start, input logic [31:0] op, input int len,
                           input logic [31:0] din_base, input bit ramp);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.cyc = start + k;
            b.op  = op;
            b.din = ramp ? din_base + 32'(k) : 32'h0;
            op_q.push_back(b);
        end
    endtask

    task automatic exp_reads(input int issue);
        rbeat_t r;
        for (int k = 0; k < 64; k++) begin
            r.cyc = issue + 1 + k;
            r.d   = 32'(issue + k);
            rd_q.push_back(r);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c0, c1, c2, d, iss;
        reset         = 1'b0;
        enable        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 32'h0;
        bus.dat_valid = 1'b0;
        bus.dat_data  = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_operation", 96'(bus.operation), 96'h0);
        chk("rst_in_data",   96'(bus.in_data),   96'h0);
        chk("rst_rd_data",   96'(bus.rd_data),   96'h0);
        chk("rst_rd_valid",  96'(bus.rd_valid),  96'h0);
        chk("rst_err",       96'(err),           96'h0);
        chk("rst_busy",      96'(busy),          96'h0);
        chk("rst_cmd_ready", 96'(bus.cmd_ready), 96'h0);
        chk("rst_dat_ready", 96'(bus.dat_ready), 96'h0);
        align();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_cmd_ready", 96'(bus.cmd_ready), 96'h1);
        chk("rel_dat_ready", 96'(bus.dat_ready), 96'h1);
        align();

        // Matmul held 80 cycles, then two gap cycles, busy drops after.
        push_cmd(32'h0001_0121, c);
        iss = c + 2;
        exp_run(iss, 32'h0001_0121, 80, 32'h0, 1'b0);
        wait_to(iss + 80);
        chk("t1_gap0_busy", 96'(busy), 96'h1);
        wait_to(iss + 81);
        chk("t1_gap1_busy", 96'(busy), 96'h1);
        wait_to(iss + 82);
        chk("t1_idle_busy", 96'(busy), 96'h0);
        align();

        // Full page write: data FIFO fills, op 2 streams words 0..63.
        for (int k = 0; k < 64; k++) push_dat(32'(k), d);
        @(negedge clk);
        chk("t2_dat_full_ready", 96'(bus.dat_ready), 96'h0);
        align();
        push_cmd(32'h0000_0002, c);
        iss = c + 2;
        exp_run(iss, 32'h0000_0002, 64, 32'h0, 1'b1);
        wait_to(iss + 66);
        chk("t2_drained_busy", 96'(busy), 96'h0);
        align();

        // Page write waits for its 64th word.
        for (int k = 0; k < 63; k++) push_dat(32'h100 + 32'(k), d);
        push_cmd(32'h0000_0002, c);
        wait_to(c + 10);
        chk("t3_wait_operation", 96'(bus.operation), 96'h0);
        chk("t3_wait_busy",      96'(busy),          96'h1);
        align();
        push_dat(32'h13F, d);
        iss = d + 2;
        exp_run(iss, 32'h0000_0002, 64, 32'h100, 1'b1);
        wait_to(iss + 66);
        chk("t3_drained_busy", 96'(busy), 96'h0);
        align();

        // Page read: 64 contiguous beats, each one the prior cycle's out_data.
        push_cmd(32'h0000_0043, c);
        iss = c + 2;
        exp_run(iss, 32'h0000_0043, 64, 32'h0, 1'b0);
        exp_reads(iss);
        wait_to(iss + 67);
        align();

        // Illegal opcode, silent opcode 0, then op 1 with no gap.
        push_cmd(32'h0000_0005, c0);
        err_q.push_back(c0 + 2);
        push_cmd(32'h0000_0000, c1);
        push_cmd(32'h0000_0001, c2);
        iss = c2 + 2;
        exp_run(iss, 32'h0000_0001, 80, 32'h0, 1'b0);
        wait_to(iss + 82);
        chk("t5_idle_busy", 96'(busy), 96'h0);
        align();

        // Enable low for five cycles mid-run: everything freezes, pushes are refused.
        push_cmd(32'h0000_0FF1, c);
        iss = c + 2;
        exp_run(iss, 32'h0000_0FF1, 85, 32'h0, 1'b0);
        wait_to(iss + 9);
        align();
        enable        = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0003;
        @(negedge clk);
        chk("t7_cmd_ready_off", 96'(bus.cmd_ready), 96'h0);
        chk("t7_dat_ready_off", 96'(bus.dat_ready), 96'h0);
        repeat (5) @(posedge clk);
        #1;
        enable        = 1'b1;
        bus.cmd_valid = 1'b0;
        wait_to(iss + 87);
        chk("t7_idle_busy", 96'(busy), 96'h0);
        align();

        // Reset at RUN cycle 30 aborts at once and discards buffered work.
        push_cmd(32'h0000_0001, c);
        iss = c + 2;
        exp_run(iss, 32'h0000_0001, 30, 32'h0, 1'b0);
        push_dat(32'h0000_00AA, d);
        push_cmd(32'h0000_0003, d);
        wait_to(iss + 29);
        align();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_abort_operation", 96'(bus.operation), 96'h0);
        chk("t6_abort_busy",      96'(busy),          96'h0);
        chk("t6_abort_cmd_ready", 96'(bus.cmd_ready), 96'h0);
        chk("t6_abort_dat_ready", 96'(bus.dat_ready), 96'h0);
        align();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rec_cmd_ready", 96'(bus.cmd_ready), 96'h1);
        chk("t6_rec_dat_ready", 96'(bus.dat_ready), 96'h1);
        repeat (100) @(negedge clk);
        chk("t6_discarded_busy", 96'(busy), 96'h0);

        chk("op_queue_drained",  96'(op_q.size()),  96'h0);
        chk("rd_queue_drained",  96'(rd_q.size()),  96'h0);
        chk("err_queue_drained", 96'(err_q.size()), 96'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
